sndcmd_sched: RTL and testbench
===============================

# sndcmd_sched

Sound-command scheduler between the main-CPU sound request (`sndno`/`sndstart`) and the System 1 sound Z80. It queues up to 2^DEPTH_LOG2 commands, presents one at a time on the command latch with an NMI, and holds the next until the sound CPU has acknowledged the NMI and read the latch. It also generates the periodic sound-CPU IRQ. Back-to-back requests from the main CPU are therefore never overwritten.

## Interface
- DEPTH_LOG2, 2, log2 of FIFO depth (default 4 entries)
- IRQ_PERIOD, 33334, clk8M cycles between IRQ assertions (1/240 s at 8 MHz)
- TIMEOUT, 65535, clk8M cycles allowed per command before abandon (only with SNDCMD_TIMEOUT_EN)

Ports:
- clk8M  in  1  single clock for all logic
- reset  in  1  asynchronous, active-high; clears all state
- sndno  in  8  command code from main CPU
- sndstart  in  1  level; rising edge requests enqueue of `sndno`
- com_rd  in  1  level, high while sound CPU reads latch address ($E000); may span several clocks
- cpu_irq  out  1  IRQ request to sound Z80
- cpu_irqa  in  1  IRQ acknowledge
- cpu_nmi  out  1  NMI request to sound Z80
- cpu_nmia  in  1  NMI acknowledge
- comlatch  out  8  current command presented to sound CPU
- busy  out  1  high when state is not IDLE
- level  out  DEPTH_LOG2+1  FIFO occupancy
- overflow  out  1  sticky; a request was dropped because FIFO was full
- timeout  out  1  sticky; a command was abandoned (constant 0 without macro)

## Operation
- Edge detect: `psndstart` register; push when `sndstart & ~psndstart`. `sndno` is sampled on that same edge.
- FIFO: circular, write and read pointers DEPTH_LOG2+1 bits wide, wrapping naturally.
  - Full when the pointer MSBs differ and the low bits are equal.
  - Push and pop in the same cycle are both honoured, including when full: the pop frees the slot and the push is accepted.
  - Push when full with no pop: the request is dropped and `overflow` is set to 1.
- State machine:
  - IDLE: if FIFO not empty, pop. Then `comlatch <= head`, `cpu_nmi <= 1`, go to ARMED.
  - ARMED: on `cpu_nmia`, `cpu_nmi <= 0` and go to WAIT_RD.
  - WAIT_RD: on `com_rd` falling edge (registered `pcom_rd & ~com_rd`), go to IDLE.
  - Any `com_rd` edge outside WAIT_RD is ignored. `cpu_nmia` outside ARMED is ignored.
- `comlatch` holds its value until the next pop and is never cleared except by reset.
- IRQ timer: counts 0..IRQ_PERIOD-1 and wraps.
  - At count IRQ_PERIOD-1, `cpu_irq <= 1`.
  - `cpu_irqa` clears `cpu_irq`. If set and acknowledge occur in the same cycle, set wins.
- The IRQ timer runs independently of the state machine.

## Timing
- Reset values: `cpu_irq`=0, `cpu_nmi`=0, `comlatch`=8'h00, `busy`=0, `level`=0, `overflow`=0, `timeout`=0, state=IDLE, timer=0, pointers=0, `psndstart`=0, `pcom_rd`=0.
- Enqueue latency: if `sndstart` is first sampled high at edge E, the entry is written at E and `level` increments after E.
- Presentation latency: if IDLE at E+1, `comlatch` and `cpu_nmi` update at E+1, i.e. visible 2 clocks after `sndstart` is sampled high.
- Next command: the pop occurs one clock after the WAIT_RD→IDLE transition at the earliest.
- First IRQ asserts IRQ_PERIOD clocks after reset release; the interval is exact thereafter.
- Reset mid-operation drops queued commands and any pending NMI immediately (asynchronous).

## Configuration
- Macro: SNDCMD_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to ARMED and counts in ARMED and WAIT_RD.
  - At TIMEOUT-1: `cpu_nmi <= 0`, state to IDLE, `timeout <= 1` (sticky).
  - A same-cycle `com_rd` falling edge takes precedence over the timeout.
- Undefined: no counter, the scheduler waits indefinitely, and `timeout` is tied to 0.

## Structure
- Shared package `sndsys_pkg` holds:
  - the state enum (IDLE, ARMED, WAIT_RD);
  - the default IRQ_PERIOD and TIMEOUT constants;
  - the latch address constant $E000, used by the decoder that drives `com_rd`.
- Sub-module `sndcmd_fifo` (parameterised by DEPTH_LOG2) provides push/pop, full/empty, level and head data.
- The FSM, edge detectors and IRQ timer live in the top module.

## Test plan
- Single command: `sndno`=8'h25, one `sndstart` pulse. `comlatch`=8'h25 and `cpu_nmi`=1 two clocks later. After `cpu_nmia`, `cpu_nmi`=0. After a 3-clock `com_rd` pulse, `busy`=0.
- Burst: 4 commands 8'h01..8'h04 pushed 2 clocks apart while the sound CPU is stalled. `level`=4, `overflow`=0. The commands are presented strictly in order, each only after the previous latch read completes.
- Overflow: 5 pushes with no pops. The fifth (8'h05) is dropped, `overflow`=1, `level`=4. Simultaneous push and pop at full: push accepted, `level` stays 4.
- IRQ: IRQ_PERIOD=10. `cpu_irq` rises at clocks 10, 20, 30. `cpu_irqa` on the same cycle as a set leaves `cpu_irq`=1.
- Reset mid-command: assert `reset` in WAIT_RD with 2 entries queued. All outputs return to reset values and no NMI follows reset release.
- With SNDCMD_TIMEOUT_EN and TIMEOUT=100, never read the latch. After 100 clocks in ARMED/WAIT_RD, `timeout`=1 and the next queued command is presented.

Source files
------------

// File: rtl/sndsys_pkg.sv
// rtl/sndsys_pkg.sv - shared sound-system types and constants
package sndsys_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    WAIT_RD = 2'd2
  } sched_state_t;

  localparam int CMD_W              = 8;
  localparam int IRQ_PERIOD_DEFAULT = 33334;
  localparam int TIMEOUT_DEFAULT    = 65535;
  localparam logic [15:0] COM_LATCH_ADDR = 16'hE000;

  // Address decode for the command latch read strobe (com_rd).
  function automatic logic is_com_latch(input logic [15:0] addr);
    return addr == COM_LATCH_ADDR;
  endfunction

endpackage

// File: rtl/sndcmd_fifo.sv
// rtl/sndcmd_fifo.sv - circular command FIFO, 2^DEPTH_LOG2 entries
module sndcmd_fifo
  import sndsys_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [CMD_W-1:0]     din,
  output logic [CMD_W-1:0]     head,
  output logic                 full,
  output logic                 empty,
  output logic [DEPTH_LOG2:0]  level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [CMD_W-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  // A pop in the same cycle frees the slot, so a push at full is still taken.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign level   = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
  end

endmodule

// File: rtl/sndcmd_sched.sv
// rtl/sndcmd_sched.sv - sound-command scheduler with NMI handshake and periodic IRQ
// Optional per-command abandon timer enabled by SNDCMD_TIMEOUT_EN.
module sndcmd_sched
  import sndsys_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2,
  parameter int IRQ_PERIOD = IRQ_PERIOD_DEFAULT,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic                clk8M,
  input  logic                reset,
  input  logic [7:0]          sndno,
  input  logic                sndstart,
  input  logic                com_rd,
  output logic                cpu_irq,
  input  logic                cpu_irqa,
  output logic                cpu_nmi,
  input  logic                cpu_nmia,
  output logic [7:0]          comlatch,
  output logic                busy,
  output logic [DEPTH_LOG2:0] level,
  output logic                overflow,
  output logic                timeout
);

  localparam int TW = $clog2(IRQ_PERIOD + 1);
  localparam logic [TW-1:0] IRQ_LAST = TW'(IRQ_PERIOD - 1);
  localparam logic [TW-1:0] IRQ_ONE  = TW'(1);

  sched_state_t state, state_n;
  logic         psndstart, pcom_rd;
  logic         push, pop, rd_fall, to_fire;
  logic         full, empty;
  logic         nmi_n;
  logic [7:0]   latch_n, head;
  logic [TW-1:0] irq_cnt;

  assign push    = sndstart & ~psndstart;
  assign rd_fall = pcom_rd & ~com_rd;
  assign busy    = (state != IDLE);

  sndcmd_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk   (clk8M),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .din   (sndno),
    .head  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk8M or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cpu_nmi   <= 1'b0;
      comlatch  <= 8'h00;
      psndstart <= 1'b0;
      pcom_rd   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      cpu_nmi   <= nmi_n;
      comlatch  <= latch_n;
      psndstart <= sndstart;
      pcom_rd   <= com_rd;
      if (push & full & ~pop) overflow <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    nmi_n   = cpu_nmi;
    latch_n = comlatch;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          latch_n = head;
          nmi_n   = 1'b1;
          state_n = ARMED;
        end
      end
      ARMED: begin
        if (cpu_nmia) begin
          nmi_n   = 1'b0;
          state_n = WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (rd_fall) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (to_fire) begin
      nmi_n   = 1'b0;
      state_n = IDLE;
    end
  end

`ifdef SNDCMD_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] to_cnt;

  // A latch read completing on the deadline cycle counts as success.
  assign to_fire = (state != IDLE) && (to_cnt == TO_LAST) &&
                   !((state == WAIT_RD) && rd_fall);

  always_ff @(posedge clk8M or posedge reset) begin
    if (reset) begin
      to_cnt  <= 16'd0;
      timeout <= 1'b0;
    end else begin
      if (state_n == ARMED && state != ARMED) to_cnt <= 16'd0;
      else if (state != IDLE)                 to_cnt <= to_cnt + 16'd1;
      if (to_fire) timeout <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign to_fire        = 1'b0;
  assign timeout        = 1'b0;
`endif

  // Free-running IRQ divider; a set on the wrap cycle beats a same-cycle acknowledge.
  always_ff @(posedge clk8M or posedge reset) begin
    if (reset) begin
      irq_cnt <= '0;
      cpu_irq <= 1'b0;
    end else begin
      if (irq_cnt == IRQ_LAST) begin
        irq_cnt <= '0;
        cpu_irq <= 1'b1;
      end else begin
        irq_cnt <= irq_cnt + IRQ_ONE;
        if (cpu_irqa) cpu_irq <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sndcmd_sched.sv
// tb/tb_sndcmd_sched.sv - directed table-driven bench for sndcmd_sched
module tb_sndcmd_sched;

  logic       clk8M = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sndno = 8'h00;
  logic       sndstart = 1'b0;
  logic       com_rd = 1'b0;
  logic       cpu_irqa = 1'b0;
  logic       cpu_nmia = 1'b0;
  logic       cpu_irq, cpu_nmi, busy, overflow, timeout;
  logic [7:0] comlatch;
  logic [2:0] level;

  int checks = 0;
  int failures = 0;

  sndcmd_sched #(.DEPTH_LOG2(2), .IRQ_PERIOD(10), .TIMEOUT(100)) dut (
    .clk8M(clk8M), .reset(reset), .sndno(sndno), .sndstart(sndstart), .com_rd(com_rd),
    .cpu_irq(cpu_irq), .cpu_irqa(cpu_irqa), .cpu_nmi(cpu_nmi), .cpu_nmia(cpu_nmia),
    .comlatch(comlatch), .busy(busy), .level(level), .overflow(overflow), .timeout(timeout)
  );

  always #5 clk8M = ~clk8M;

  typedef struct {
    logic       st;
    logic [7:0] no;
    logic       rd;
    logic       ack;
    logic [7:0] e_latch;
    logic       e_nmi;
    logic       e_busy;
    logic [2:0] e_level;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic st, input logic [7:0] no, input logic rd, input logic ack,
                              input logic [7:0] e_latch, input logic e_nmi, input logic e_busy,
                              input logic [2:0] e_level, input logic e_ovf);
    vec_t v;
    v.st = st; v.no = no; v.rd = rd; v.ack = ack;
    v.e_latch = e_latch; v.e_nmi = e_nmi; v.e_busy = e_busy; v.e_level = e_level; v.e_ovf = e_ovf;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic st, input logic [7:0] no, input logic rd, input logic ack);
    sndstart = st;
    sndno    = no;
    com_rd   = rd;
    cpu_nmia = ack;
    @(posedge clk8M);
    #1;
  endtask

  task automatic serve(input logic [7:0] nxt, input logic [2:0] lvl, input logic more);
    cycle(0, 8'h00, 0, 1);
    chk("serve_nmi_ack", cpu_nmi, 0);
    cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 0, 0);
    chk("serve_busy_after_rd", busy, 0);
    cycle(0, 8'h00, 0, 0);
    if (more) begin
      chk("serve_next_latch", comlatch, nxt);
      chk("serve_next_nmi", cpu_nmi, 1);
      chk("serve_next_level", level, lvl);
    end else begin
      chk("serve_idle_busy", busy, 0);
      chk("serve_idle_nmi", cpu_nmi, 0);
      chk("serve_hold_latch", comlatch, nxt);
    end
  endtask

  initial begin
    logic       m_irq;
    logic [7:0] nxt [4];
    logic [2:0] lvl [4];

    // Single command (held in WAIT_RD), burst while stalled, in-order service.
    add(1, 8'h25, 0, 0, 8'h00, 0, 0, 1, 0);
    add(1, 8'h25, 0, 0, 8'h25, 1, 1, 0, 0);
    add(0, 8'h00, 0, 1, 8'h25, 0, 1, 0, 0);
    add(1, 8'h01, 0, 0, 8'h25, 0, 1, 1, 0);
    add(0, 8'h00, 0, 0, 8'h25, 0, 1, 1, 0);
    add(1, 8'h02, 0, 0, 8'h25, 0, 1, 2, 0);
    add(0, 8'h00, 0, 0, 8'h25, 0, 1, 2, 0);
    add(1, 8'h03, 0, 0, 8'h25, 0, 1, 3, 0);
    add(0, 8'h00, 0, 0, 8'h25, 0, 1, 3, 0);
    add(1, 8'h04, 0, 0, 8'h25, 0, 1, 4, 0);
    add(0, 8'h00, 0, 0, 8'h25, 0, 1, 4, 0);
    add(0, 8'h00, 1, 0, 8'h25, 0, 1, 4, 0);
    add(0, 8'h00, 1, 0, 8'h25, 0, 1, 4, 0);
    add(0, 8'h00, 1, 0, 8'h25, 0, 1, 4, 0);
    add(0, 8'h00, 0, 0, 8'h25, 0, 0, 4, 0);
    add(0, 8'h00, 0, 0, 8'h01, 1, 1, 3, 0);
    add(0, 8'h00, 0, 1, 8'h01, 0, 1, 3, 0);
    add(0, 8'h00, 0, 0, 8'h01, 0, 1, 3, 0);
    add(0, 8'h00, 1, 0, 8'h01, 0, 1, 3, 0);
    add(0, 8'h00, 0, 0, 8'h01, 0, 0, 3, 0);
    add(0, 8'h00, 0, 0, 8'h02, 1, 1, 2, 0);
    add(0, 8'h00, 1, 0, 8'h02, 1, 1, 2, 0);
    add(0, 8'h00, 0, 0, 8'h02, 1, 1, 2, 0);
    add(0, 8'h00, 0, 1, 8'h02, 0, 1, 2, 0);
    add(0, 8'h00, 1, 0, 8'h02, 0, 1, 2, 0);
    add(0, 8'h00, 0, 0, 8'h02, 0, 0, 2, 0);
    add(0, 8'h00, 0, 0, 8'h03, 1, 1, 1, 0);
    add(0, 8'h00, 0, 1, 8'h03, 0, 1, 1, 0);
    add(0, 8'h00, 1, 0, 8'h03, 0, 1, 1, 0);
    add(0, 8'h00, 0, 0, 8'h03, 0, 0, 1, 0);
    add(0, 8'h00, 0, 0, 8'h04, 1, 1, 0, 0);
    add(0, 8'h00, 0, 1, 8'h04, 0, 1, 0, 0);
    add(0, 8'h00, 0, 0, 8'h04, 0, 1, 0, 0);
    // Overflow: five pushes while 04 awaits its read, fifth dropped.
    add(1, 8'h01, 0, 0, 8'h04, 0, 1, 1, 0);
    add(0, 8'h00, 0, 0, 8'h04, 0, 1, 1, 0);
    add(1, 8'h02, 0, 0, 8'h04, 0, 1, 2, 0);
    add(0, 8'h00, 0, 0, 8'h04, 0, 1, 2, 0);
    add(1, 8'h03, 0, 0, 8'h04, 0, 1, 3, 0);
    add(0, 8'h00, 0, 0, 8'h04, 0, 1, 3, 0);
    add(1, 8'h04, 0, 0, 8'h04, 0, 1, 4, 0);
    add(0, 8'h00, 0, 0, 8'h04, 0, 1, 4, 0);
    add(1, 8'h05, 0, 0, 8'h04, 0, 1, 4, 1);
    add(0, 8'h00, 0, 0, 8'h04, 0, 1, 4, 1);
    add(0, 8'h00, 1, 0, 8'h04, 0, 1, 4, 1);
    add(0, 8'h00, 0, 0, 8'h04, 0, 0, 4, 1);
    // Push and pop together at full.
    add(1, 8'h06, 0, 0, 8'h01, 1, 1, 4, 1);

    // Reset values while reset is held.
    #12;
    chk("rst_irq", cpu_irq, 0);
    chk("rst_nmi", cpu_nmi, 0);
    chk("rst_latch", comlatch, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_timeout", timeout, 0);
    @(posedge clk8M);
    #1 reset = 1'b0;

    // IRQ every 10 clocks; acknowledge on a set cycle loses.
    m_irq = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      cpu_irqa = (k == 11 || k == 20 || k == 21);
      @(posedge clk8M);
      #1;
      if (k % 10 == 0) m_irq = 1'b1;
      else if (cpu_irqa) m_irq = 1'b0;
      chk($sformatf("irq_k%0d", k), cpu_irq, m_irq);
    end
    cpu_irqa = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].st, vecs[i].no, vecs[i].rd, vecs[i].ack);
      chk($sformatf("v%0d_latch", i), comlatch, vecs[i].e_latch);
      chk($sformatf("v%0d_nmi", i), cpu_nmi, vecs[i].e_nmi);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
      chk($sformatf("v%0d_level", i), level, vecs[i].e_level);
      chk($sformatf("v%0d_ovf", i), overflow, vecs[i].e_ovf);
      chk($sformatf("v%0d_timeout", i), timeout, 0);
    end

    // Drain: 05 was dropped, 06 landed behind 04.
    nxt[0] = 8'h02; nxt[1] = 8'h03; nxt[2] = 8'h04; nxt[3] = 8'h06;
    lvl[0] = 3'd3;  lvl[1] = 3'd2;  lvl[2] = 3'd1;  lvl[3] = 3'd0;
    for (int j = 0; j < 4; j++) serve(nxt[j], lvl[j], 1'b1);
    serve(8'h06, 3'd0, 1'b0);

    // Reset in WAIT_RD with two entries queued.
    cycle(1, 8'h31, 0, 0);
    cycle(0, 8'h00, 0, 0);
    cycle(0, 8'h00, 0, 1);
    cycle(1, 8'h32, 0, 0);
    cycle(0, 8'h00, 0, 0);
    cycle(1, 8'h33, 0, 0);
    cycle(0, 8'h00, 0, 0);
    chk("pre_rst_level", level, 2);
    chk("pre_rst_busy", busy, 1);
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_latch", comlatch, 8'h00);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_nmi", cpu_nmi, 0);
    chk("mid_rst_irq", cpu_irq, 0);
    @(posedge clk8M);
    #1 reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle(0, 8'h00, 0, 0);
      chk($sformatf("post_rst_nmi%0d", k), cpu_nmi, 0);
      chk($sformatf("post_rst_busy%0d", k), busy, 0);
    end

    // Never read the latch: abandon after 100 clocks, or wait forever.
    cycle(1, 8'h41, 0, 0);
    cycle(0, 8'h00, 0, 0);
    chk("to_first_latch", comlatch, 8'h41);
    cycle(1, 8'h42, 0, 0);
    for (int k = 0; k < 98; k++) cycle(0, 8'h00, 0, 0);
    chk("to_before_flag", timeout, 0);
    chk("to_before_busy", busy, 1);
    cycle(0, 8'h00, 0, 0);
`ifdef SNDCMD_TIMEOUT_EN
    chk("to_fire_flag", timeout, 1);
    chk("to_fire_busy", busy, 0);
    chk("to_fire_nmi", cpu_nmi, 0);
    cycle(0, 8'h00, 0, 0);
    chk("to_next_latch", comlatch, 8'h42);
    chk("to_next_nmi", cpu_nmi, 1);
    chk("to_sticky", timeout, 1);
`else
    chk("nto_flag", timeout, 0);
    chk("nto_busy", busy, 1);
    chk("nto_nmi", cpu_nmi, 1);
    cycle(0, 8'h00, 0, 0);
    chk("nto_latch", comlatch, 8'h41);
    chk("nto_level", level, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
